// File: rtl/emu_doppler_ctrl_if.sv
// rtl/emu_doppler_ctrl_if.sv - segment configuration handshake bus for the Doppler sequencer
interface emu_doppler_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_freq;
    logic [31:0] cfg_rate;
    logic [15:0] cfg_count;

    modport master (
        output cfg_valid,
        output cfg_freq,
        output cfg_rate,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_freq,
        input  cfg_rate,
        input  cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/emu_doppler_ctrl.sv
// rtl/emu_doppler_ctrl.sv - Doppler profile sequencer driving the NCO frequency word per epoch
module emu_doppler_ctrl #(
    parameter int EPOCH_LEN = 16368
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    emu_doppler_ctrl_if.slave   cfg,
    input  logic                start,
    input  logic                stop,
    output logic                nco_dv,
    output logic [31:0]         nco_freq,
    output logic                busy,
    output logic                epoch_tick,
    output logic                seg_done,
    output logic                done
);

    localparam int CNT_W = (EPOCH_LEN > 2) ? $clog2(EPOCH_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(EPOCH_LEN - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [31:0]      act_freq;
    logic [31:0]      act_rate;
    logic [16:0]      epochs_left;
    logic [CNT_W-1:0] sample_cnt;

    logic [31:0]      sh_freq;
    logic [31:0]      sh_rate;
    logic [15:0]      sh_count;
    logic             sh_full;
    logic             ready_q;

    logic             take;
    logic             sample;
    logic             epoch_end;
    logic             last_epoch;
    logic             load_start;
    logic             load_chain;

    function automatic logic [16:0] epochs_of(input logic [15:0] count);
        return (count == 16'd0) ? 17'd1 : {1'b0, count};
    endfunction

    assign cfg.cfg_ready = ready_q;
    assign busy          = (state == S_RUN);

    assign take       = cfg.cfg_valid && ready_q;
    assign sample     = (state == S_RUN) && sample_en && !stop;
    assign epoch_end  = sample && (sample_cnt == LAST_SAMPLE);
    assign last_epoch = (epochs_left <= 17'd1);
    assign load_start = (state == S_IDLE) && start && sh_full && !stop;
    assign load_chain = epoch_end && last_epoch && sh_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            act_freq    <= '0;
            act_rate    <= '0;
            epochs_left <= '0;
            sample_cnt  <= '0;
            sh_freq     <= '0;
            sh_rate     <= '0;
            sh_count    <= '0;
            sh_full     <= 1'b0;
            ready_q     <= 1'b1;
            nco_dv      <= 1'b0;
            nco_freq    <= '0;
            epoch_tick  <= 1'b0;
            seg_done    <= 1'b0;
            done        <= 1'b0;
        end else begin
            nco_dv     <= 1'b0;
            epoch_tick <= 1'b0;
            seg_done   <= 1'b0;
            done       <= 1'b0;

            // A transfer needs ready, a load needs full: they are mutually exclusive.
            if (take) begin
                sh_freq  <= cfg.cfg_freq;
                sh_rate  <= cfg.cfg_rate;
                sh_count <= cfg.cfg_count;
                sh_full  <= 1'b1;
                ready_q  <= 1'b0;
            end else if (load_start || load_chain) begin
                sh_full  <= 1'b0;
                ready_q  <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        act_freq    <= sh_freq;
                        act_rate    <= sh_rate;
                        epochs_left <= epochs_of(sh_count);
                        sample_cnt  <= '0;
                        nco_freq    <= sh_freq;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_IDLE;
                    end else if (sample_en) begin
                        // nco_freq carries this sample's epoch frequency; act_freq already
                        // moves on so the next sample starts the new epoch without a gap.
                        nco_dv   <= 1'b1;
                        nco_freq <= act_freq;
                        if (epoch_end) begin
                            sample_cnt <= '0;
                            epoch_tick <= 1'b1;
                            if (!last_epoch) begin
                                epochs_left <= epochs_left - 17'd1;
                                act_freq    <= act_freq + act_rate;
                            end else if (sh_full) begin
                                act_freq    <= sh_freq;
                                act_rate    <= sh_rate;
                                epochs_left <= epochs_of(sh_count);
                                seg_done    <= 1'b1;
                            end else begin
                                epochs_left <= epochs_left - 17'd1;
                                done        <= 1'b1;
                                state       <= S_IDLE;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
